data_cache: RTL and testbench
=============================

DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameter LINES, default 16, number of direct-mapped lines (power of two).
REQ-002 Parameter WORDS, default 4, 32-bit words per line (power of two).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cpu_addr  input  32  CPU byte address; bits [1:0] ignored.
REQ-006 cpu_re  input  1  CPU load request.
REQ-007 cpu_we  input  1  CPU store request.
REQ-008 cpu_wdata  input  32  store data.
REQ-009 cpu_rdata  output  32  load data, valid when cpu_re=1 and stall=0.
REQ-010 stall  output  1  CPU shall hold its request and pipeline while 1.
REQ-011 mem_addr  output  32  backing-memory word address (byte address, [1:0]=0).
REQ-012 mem_re  output  1  backing-memory read strobe.
REQ-013 mem_we  output  1  backing-memory write strobe.
REQ-014 mem_wdata  output  32  backing-memory write data.
REQ-015 mem_rdata  input  32  backing-memory read data, valid with mem_ack.
REQ-016 mem_ack  input  1  one-cycle completion of the current mem_re/mem_we beat.

Function
REQ-017 Address split (defaults): offset=addr[3:2], index=addr[7:4], tag=addr[31:8]; widths derive from LINES/WORDS.
REQ-018 Hit = valid[index] and stored tag equals address tag, evaluated combinationally.
REQ-019 FSM states: IDLE, REFILL, WRITE.
REQ-020 IDLE, cpu_re hit: cpu_rdata = stored word, stall=0, same cycle (zero added latency).
REQ-021 IDLE, cpu_re miss: stall=1, next state REFILL, beat counter cleared.
REQ-022 REFILL: mem_re=1, mem_addr={tag,index,beat,2'b00}; on mem_ack store mem_rdata into word beat, increment beat; stall=1 throughout.
REQ-023 REFILL after ack of beat WORDS-1: write tag, set valid, return to IDLE; retried load then hits (miss total = refill beats + 1 cycle).
REQ-024 Valid bit of the refilling line shall be cleared on REFILL entry so a partial line is never hit.
REQ-025 IDLE, cpu_we: stall=1, next state WRITE (write-through, no-write-allocate).
REQ-026 WRITE: mem_we=1, mem_addr=cpu_addr word-aligned, mem_wdata=cpu_wdata; stall = !mem_ack; on mem_ack, if hit update stored word, return to IDLE.
REQ-027 cpu_re and cpu_we both 1: treated as store; cpu_rdata undefined.
REQ-028 mem_re and mem_we shall never be 1 simultaneously; both 0 in IDLE.
REQ-029 mem_ack in IDLE shall be ignored.
REQ-030 Neither request: stall=0, no state change.
REQ-031 cpu_addr/cpu_wdata shall be sampled live; CPU guarantees stability while stall=1.

Reset
REQ-032 rst forces state IDLE, beat=0, all valid bits 0, mem_re=0, mem_we=0; stall then follows REQ-020..REQ-030 combinationally.
REQ-033 rst during REFILL aborts it; the line stays invalid; in-flight mem_ack after reset ignored.
REQ-034 rst during WRITE abandons the store; cache contents unchanged.
REQ-035 Tag and data arrays need not be reset.

Structure
REQ-036 State encodings, default LINES/WORDS and address-field widths shall live in the shared CPU parameter header.
REQ-037 Tag/valid/data storage shall be one sub-module, cache_array (read comb, write sync, valid-clear port).
REQ-038 Cache shall sit between the CPU data-memory port and data memory, with stall OR-ed into the CPU's global stall.

Verification
REQ-039 After reset, load 0x100 (mem returns 0xA0..0xA3 for 0x100..0x10C, ack every cycle) -> 4 mem_re beats at 0x100,0x104,0x108,0x10C, stall 5 cycles, cpu_rdata=0xA0.
REQ-040 Then load 0x108 -> stall=0 same cycle, cpu_rdata=0xA2, mem_re=0.
REQ-041 Store 0xDEAD to 0x104 (hit), ack after 3 cycles -> mem_we with addr 0x104 for 3 cycles, stall drops on ack cycle; later load 0x104 hits returning 0xDEAD.
REQ-042 Store 0x55 to 0x400 (miss) -> one write beat, no refill; load 0x400 then misses and refills.
REQ-043 Load 0x200 conflicts index with 0x100 (both index 0) -> refill evicts; load 0x100 then misses.
REQ-044 rst asserted after 2nd refill beat -> mem_re=0 next cycle; load same address afterwards performs full 4-beat refill.

Source files
------------

// File: rtl/data_cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : data_cache_pkg
//  Purpose  : Shared CPU-side parameters for the data cache: default geometry,
//             address field widths and FSM state encoding.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package data_cache_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned BYTE_OFF_W = 2;

  // Default geometry: 16 lines x 4 words
  localparam int unsigned LINES_DEF  = 16;
  localparam int unsigned WORDS_DEF  = 4;

  // Field widths derived from the geometry
  localparam int unsigned OFF_W_DEF  = $clog2(WORDS_DEF);
  localparam int unsigned IDX_W_DEF  = $clog2(LINES_DEF);
  localparam int unsigned TAG_W_DEF  = ADDR_W - BYTE_OFF_W - IDX_W_DEF - OFF_W_DEF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_WRITE  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/data_cache_if.sv
`default_nettype none
// ============================================================================
//  Module   : data_cache_if
//  Purpose  : Bundles the CPU data port and the backing-memory port seen by
//             the data cache.
//  Ports    : slave  - cache view (takes CPU requests, issues memory beats)
//             master - environment view (CPU + memory side)
//  Revision : 1.0 - initial release
// ============================================================================
interface data_cache_if;
  import data_cache_pkg::*;

  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_re;
  logic              cpu_we;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              stall;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport slave (
    input  cpu_addr, cpu_re, cpu_we, cpu_wdata, mem_rdata, mem_ack,
    output cpu_rdata, stall, mem_addr, mem_re, mem_we, mem_wdata
  );

  modport master (
    output cpu_addr, cpu_re, cpu_we, cpu_wdata, mem_rdata, mem_ack,
    input  cpu_rdata, stall, mem_addr, mem_re, mem_we, mem_wdata
  );

endinterface
`default_nettype wire

// File: rtl/data_cache_array.sv
`default_nettype none
// ============================================================================
//  Module   : cache_array
//  Purpose  : Tag / valid / data storage of the direct-mapped cache.
//             Reads are combinational, writes are synchronous.
//  Ports    : clk, rst     - clock, synchronous active-high reset (valid only)
//             index_i      - line selected for every read and write
//             rd_offset_i  - word read on rd_data_o
//             tag_o/valid_o/rd_data_o - stored tag, valid bit, word
//             inval_i      - clear valid bit of index_i
//             tag_we_i     - write tag_i and set valid bit of index_i
//             data_we_i    - write wr_data_i into word wr_offset_i
//  Revision : 1.0 - initial release
// ============================================================================
module cache_array
  import data_cache_pkg::*;
#(
  parameter int unsigned LINES = LINES_DEF,
  parameter int unsigned WORDS = WORDS_DEF,
  parameter int unsigned IDX_W = $clog2(LINES),
  parameter int unsigned OFF_W = $clog2(WORDS),
  parameter int unsigned TAG_W = ADDR_W - BYTE_OFF_W - IDX_W - OFF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  index_i,
  input  logic [OFF_W-1:0]  rd_offset_i,
  output logic [TAG_W-1:0]  tag_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              inval_i,
  input  logic              tag_we_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic              data_we_i,
  input  logic [OFF_W-1:0]  wr_offset_i,
  input  logic [DATA_W-1:0] wr_data_i
);

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES*WORDS];

  assign valid_o   = valid_q[index_i];
  assign tag_o     = tag_q[index_i];
  assign rd_data_o = data_q[{index_i, rd_offset_i}];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (inval_i) begin
      valid_q[index_i] <= 1'b0;
    end else if (tag_we_i) begin
      valid_q[index_i] <= 1'b1;
    end
  end

  // Tag and data contents are meaningless while the valid bit is clear,
  // so they carry no reset.
  always_ff @(posedge clk) begin
    if (tag_we_i) begin
      tag_q[index_i] <= tag_i;
    end
    if (data_we_i) begin
      data_q[{index_i, wr_offset_i}] <= wr_data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/data_cache.sv
`default_nettype none
// ============================================================================
//  Module   : data_cache
//  Purpose  : Direct-mapped, write-through, no-write-allocate data cache
//             between the CPU data port and backing memory. Load hits
//             return data in the same cycle; misses refill the whole line
//             one word per memory beat.
//  Ports    : clk  - clock
//             rst  - synchronous active-high reset
//             bus  - data_cache_if.slave (CPU request/stall, memory beats)
//  Revision : 1.0 - initial release
// ============================================================================
module data_cache
  import data_cache_pkg::*;
#(
  parameter int unsigned LINES = LINES_DEF,
  parameter int unsigned WORDS = WORDS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  data_cache_if.slave bus
);

  localparam int unsigned OFF_W = $clog2(WORDS);
  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = ADDR_W - BYTE_OFF_W - IDX_W - OFF_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS - 1);

  state_e            state_q, state_d;
  logic [OFF_W-1:0]  beat_q, beat_d;

  logic [OFF_W-1:0]  addr_off;
  logic [IDX_W-1:0]  addr_idx;
  logic [TAG_W-1:0]  addr_tag;
  logic [TAG_W-1:0]  arr_tag;
  logic              arr_valid;
  logic [DATA_W-1:0] arr_rdata;
  logic              hit;

  logic              inval;
  logic              tag_we;
  logic              data_we;
  logic [OFF_W-1:0]  wr_off;
  logic [DATA_W-1:0] wr_data;

  assign addr_off = bus.cpu_addr[BYTE_OFF_W +: OFF_W];
  assign addr_idx = bus.cpu_addr[BYTE_OFF_W + OFF_W +: IDX_W];
  assign addr_tag = bus.cpu_addr[ADDR_W-1 -: TAG_W];
  assign hit      = arr_valid && (arr_tag == addr_tag);

  // The CPU holds its address while stalled, so the live index also
  // addresses the line being refilled or written.
  cache_array #(
    .LINES (LINES),
    .WORDS (WORDS),
    .IDX_W (IDX_W),
    .OFF_W (OFF_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk         (clk),
    .rst         (rst),
    .index_i     (addr_idx),
    .rd_offset_i (addr_off),
    .tag_o       (arr_tag),
    .valid_o     (arr_valid),
    .rd_data_o   (arr_rdata),
    .inval_i     (inval),
    .tag_we_i    (tag_we && !rst),
    .tag_i       (addr_tag),
    .data_we_i   (data_we && !rst),
    .wr_offset_i (wr_off),
    .wr_data_i   (wr_data)
  );

  assign bus.cpu_rdata = arr_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    bus.stall     = 1'b0;
    bus.mem_re    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = {bus.cpu_addr[ADDR_W-1:BYTE_OFF_W], 2'b00};
    bus.mem_wdata = bus.cpu_wdata;
    inval         = 1'b0;
    tag_we        = 1'b0;
    data_we       = 1'b0;
    wr_off        = addr_off;
    wr_data       = bus.cpu_wdata;

    unique case (state_q)
      ST_IDLE: begin
        // A store wins over a simultaneous load; mem_ack is ignored here.
        if (bus.cpu_we) begin
          bus.stall = 1'b1;
          state_d   = ST_WRITE;
        end else if (bus.cpu_re && !hit) begin
          bus.stall = 1'b1;
          state_d   = ST_REFILL;
          beat_d    = '0;
          // Drop the line now so a partially refilled line never hits.
          inval     = 1'b1;
        end
      end

      ST_REFILL: begin
        bus.stall    = 1'b1;
        bus.mem_re   = 1'b1;
        bus.mem_addr = {addr_tag, addr_idx, beat_q, 2'b00};
        if (bus.mem_ack) begin
          data_we = 1'b1;
          wr_off  = beat_q;
          wr_data = bus.mem_rdata;
          beat_d  = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            tag_we  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end

      ST_WRITE: begin
        bus.mem_we = 1'b1;
        bus.stall  = !bus.mem_ack;
        if (bus.mem_ack) begin
          // Write-through: keep a resident copy coherent, never allocate.
          data_we = hit;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_data_cache.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_cache
//  Purpose  : Self-checking bench for data_cache. A memory responder with a
//             programmable ack delay backs the cache; a residency model of
//             the direct-mapped lines predicts hit/miss and stall length,
//             and the golden memory predicts load data.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_cache;

  localparam int LINES = 16;
  localparam int WORDS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_cache_if bus();

  data_cache #(.LINES(LINES), .WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Backing memory and responder state
  logic [31:0] gmem [logic [31:0]];
  int          ack_delay = 0;
  logic        resp_ack  = 1'b0;
  logic        force_ack = 1'b0;
  logic [31:0] resp_rdata = '0;
  int          waited = 0;
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic [31:0] re_log[$];
  logic [31:0] we_addr_log[$];
  int          we_cycles = 0;
  logic        overlap = 1'b0;

  assign bus.mem_ack   = resp_ack | force_ack;
  assign bus.mem_rdata = resp_rdata;

  // Residency model: which tag each line holds
  bit          ref_valid [LINES];
  logic [23:0] ref_tag   [LINES];

  function automatic logic [31:0] mem_val(logic [31:0] a);
    if (gmem.exists(a)) return gmem[a];
    return a ^ 32'h3C5A_0000;
  endfunction

  // Returns the expected stall length of a load and records the line fill.
  function automatic int exp_load_stall(logic [31:0] a);
    int idx;
    idx = int'((a >> 4) & 32'hF);
    if (ref_valid[idx] && ref_tag[idx] == a[31:8]) return 0;
    ref_valid[idx] = 1'b1;
    ref_tag[idx]   = a[31:8];
    return 1 + WORDS * (ack_delay + 1);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < LINES; i++) ref_valid[i] = 1'b0;
  endfunction

  // Memory responder: each beat is acked after ack_delay waiting cycles.
  always @(posedge clk) begin
    #1;
    if (prev_ack || !prev_req) waited = 0;
    else waited = waited + 1;
    if (bus.mem_re || bus.mem_we) begin
      resp_ack   = (waited >= ack_delay);
      resp_rdata = mem_val(bus.mem_addr);
    end else begin
      resp_ack   = 1'b0;
      resp_rdata = '0;
    end
  end

  // Bus monitor: beat logs and memory writes, sampled mid-cycle.
  always @(negedge clk) begin
    prev_req = bus.mem_re || bus.mem_we;
    prev_ack = bus.mem_ack;
    if (bus.mem_re && bus.mem_we) overlap = 1'b1;
    if (bus.mem_re && bus.mem_ack) re_log.push_back(bus.mem_addr);
    if (bus.mem_we) we_cycles = we_cycles + 1;
    if (bus.mem_we && bus.mem_ack) begin
      we_addr_log.push_back(bus.mem_addr);
      gmem[bus.mem_addr] = bus.mem_wdata;
    end
  end

  // One CPU access: holds the request until stall drops.
  task automatic cpu_op(input bit we, input bit re, input logic [31:0] a,
                        input logic [31:0] wd, output int stalls,
                        output logic [31:0] rd, output bit timeout);
    @(posedge clk); #2;
    bus.cpu_addr  = a;
    bus.cpu_re    = re;
    bus.cpu_we    = we;
    bus.cpu_wdata = wd;
    stalls  = 0;
    timeout = 1'b0;
    rd      = '0;
    forever begin
      @(negedge clk);
      if (!bus.stall) begin
        rd = bus.cpu_rdata;
        break;
      end
      stalls++;
      if (stalls > 200) begin
        timeout = 1'b1;
        break;
      end
    end
    @(posedge clk); #2;
    bus.cpu_re = 1'b0;
    bus.cpu_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++; $display("FAIL reset_stall: got %b expected 0", bus.stall);
    end
    checks++;
    if (bus.mem_re !== 1'b0 || bus.mem_we !== 1'b0) begin
      errors++; $display("FAIL reset_mem: got re=%b we=%b expected 0/0", bus.mem_re, bus.mem_we);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_refill();
    logic [31:0] rd; int st; bit to; int e; bit ok;
    ack_delay = 0;
    for (int k = 0; k < 4; k++) gmem[32'h100 + 32'(4*k)] = 32'hA0 + 32'(k);
    e = exp_load_stall(32'h100);
    re_log.delete(); overlap = 1'b0;
    cpu_op(1'b0, 1'b1, 32'h100, '0, st, rd, to);
    checks++;
    if (to || rd !== 32'hA0) begin
      errors++; $display("FAIL refill_data: got %h expected 000000a0", rd);
    end
    checks++;
    if (st != 5 || e != 5) begin
      errors++; $display("FAIL refill_stall: got %0d expected 5", st);
    end
    ok = (re_log.size() == 4);
    for (int k = 0; k < 4 && ok; k++)
      if (re_log[k] !== 32'h100 + 32'(4*k)) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++; $display("FAIL refill_beats: got %0d beats expected 4 at 0x100..0x10c", re_log.size());
    end
    checks++;
    if (overlap) begin
      errors++; $display("FAIL refill_overlap: got mem_re&mem_we expected exclusive");
    end
  endtask

  task automatic test_hit();
    logic [31:0] rd; int st; bit to; int e;
    re_log.delete();
    e = exp_load_stall(32'h108);
    cpu_op(1'b0, 1'b1, 32'h108, '0, st, rd, to);
    checks++;
    if (to || rd !== 32'hA2) begin
      errors++; $display("FAIL hit_data: got %h expected 000000a2", rd);
    end
    checks++;
    if (st != 0 || e != 0 || re_log.size() != 0) begin
      errors++; $display("FAIL hit_latency: got stall=%0d beats=%0d expected 0/0", st, re_log.size());
    end
  endtask

  task automatic test_store_hit();
    logic [31:0] rd; int st; bit to; int e;
    ack_delay = 2;
    we_addr_log.delete(); we_cycles = 0;
    cpu_op(1'b1, 1'b0, 32'h104, 32'hDEAD, st, rd, to);
    checks++;
    if (to || st != 3 || we_cycles != 3) begin
      errors++; $display("FAIL store_hit_timing: got stall=%0d we_cycles=%0d expected 3/3", st, we_cycles);
    end
    checks++;
    if (we_addr_log.size() != 1 || we_addr_log[0] !== 32'h104 || mem_val(32'h104) !== 32'hDEAD) begin
      errors++; $display("FAIL store_hit_bus: got %0d writes mem=%h expected 1 write of dead at 104",
                         we_addr_log.size(), mem_val(32'h104));
    end
    ack_delay = 0;
    e = exp_load_stall(32'h104);
    cpu_op(1'b0, 1'b1, 32'h104, '0, st, rd, to);
    checks++;
    if (to || rd !== 32'hDEAD || st != 0 || e != 0) begin
      errors++; $display("FAIL store_hit_reload: got %h stall=%0d expected 0000dead stall=0", rd, st);
    end
  endtask

  task automatic test_store_miss();
    logic [31:0] rd; int st; bit to; int e;
    ack_delay = 0;
    re_log.delete(); we_addr_log.delete();
    cpu_op(1'b1, 1'b0, 32'h400, 32'h55, st, rd, to);
    checks++;
    if (to || st != 1 || re_log.size() != 0 || we_addr_log.size() != 1 || we_addr_log[0] !== 32'h400) begin
      errors++; $display("FAIL store_miss: got stall=%0d reads=%0d writes=%0d expected 1/0/1",
                         st, re_log.size(), we_addr_log.size());
    end
    e = exp_load_stall(32'h400);
    cpu_op(1'b0, 1'b1, 32'h400, '0, st, rd, to);
    checks++;
    if (to || rd !== 32'h55 || st != e || e != 5) begin
      errors++; $display("FAIL store_miss_reload: got %h stall=%0d expected 00000055 stall=5", rd, st);
    end
  endtask

  task automatic test_conflict();
    logic [31:0] rd; int st; bit to; int e;
    re_log.delete();
    e = exp_load_stall(32'h200);
    cpu_op(1'b0, 1'b1, 32'h200, '0, st, rd, to);
    checks++;
    if (to || st != e || re_log.size() != 4 || re_log[0] !== 32'h200 || rd !== mem_val(32'h200)) begin
      errors++; $display("FAIL conflict_fill: got stall=%0d data=%h expected stall=%0d data=%h",
                         st, rd, e, mem_val(32'h200));
    end
    e = exp_load_stall(32'h100);
    cpu_op(1'b0, 1'b1, 32'h100, '0, st, rd, to);
    checks++;
    if (to || st != 5 || e != 5 || rd !== 32'hA0) begin
      errors++; $display("FAIL conflict_evict: got stall=%0d data=%h expected stall=5 data=000000a0", st, rd);
    end
  endtask

  task automatic test_reset_refill();
    logic [31:0] rd; int st; bit to; int e; int n;
    ack_delay = 0;
    n = 0;
    @(posedge clk); #2;
    bus.cpu_addr = 32'h300;
    bus.cpu_re   = 1'b1;
    for (int c = 0; c < 50 && n < 2; c++) begin
      @(negedge clk);
      if (bus.mem_re && bus.mem_ack) n++;
    end
    checks++;
    if (n != 2) begin
      errors++; $display("FAIL rst_refill_beats: got %0d beats expected 2", n);
    end
    @(posedge clk); #2;
    rst = 1'b1;
    bus.cpu_re = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.mem_re !== 1'b0) begin
      errors++; $display("FAIL rst_refill_abort: got mem_re=%b expected 0", bus.mem_re);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    force_ack = 1'b1;
    model_reset();
    @(negedge clk);
    checks++;
    if (bus.stall !== 1'b0 || bus.mem_re !== 1'b0 || bus.mem_we !== 1'b0) begin
      errors++; $display("FAIL idle_stray_ack: got stall=%b re=%b we=%b expected 0/0/0",
                         bus.stall, bus.mem_re, bus.mem_we);
    end
    @(posedge clk); #2;
    force_ack = 1'b0;
    re_log.delete();
    e = exp_load_stall(32'h300);
    cpu_op(1'b0, 1'b1, 32'h300, '0, st, rd, to);
    checks++;
    if (to || st != 5 || e != 5 || re_log.size() != 4 || re_log[0] !== 32'h300 || rd !== mem_val(32'h300)) begin
      errors++; $display("FAIL rst_refill_retry: got stall=%0d beats=%0d data=%h expected 5/4/%h",
                         st, re_log.size(), rd, mem_val(32'h300));
    end
  endtask

  task automatic test_random();
    logic [31:0] a, wd, rd, exp_rd; int st; bit to; int e;
    overlap = 1'b0;
    for (int n = 0; n < 80; n++) begin
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 4) |
          (32'($urandom_range(0, 3)) << 2);
      ack_delay = int'($urandom_range(0, 2));
      if ($urandom_range(0, 9) < 4) begin
        wd = $urandom;
        we_cycles = 0;
        we_addr_log.delete(); re_log.delete();
        cpu_op(1'b1, 1'($urandom_range(0, 1)), a, wd, st, rd, to);
        checks++;
        if (to || st != 1 + ack_delay || we_cycles != 1 + ack_delay) begin
          errors++; $display("FAIL rnd_store_timing: got stall=%0d we_cycles=%0d expected %0d",
                             st, we_cycles, 1 + ack_delay);
        end
        checks++;
        if (we_addr_log.size() != 1 || we_addr_log[0] !== a || mem_val(a) !== wd || re_log.size() != 0) begin
          errors++; $display("FAIL rnd_store_bus: addr %h got mem=%h writes=%0d expected mem=%h writes=1",
                             a, mem_val(a), we_addr_log.size(), wd);
        end
      end else begin
        exp_rd = mem_val(a);
        e = exp_load_stall(a);
        re_log.delete();
        cpu_op(1'b0, 1'b1, a, '0, st, rd, to);
        checks++;
        if (to || rd !== exp_rd) begin
          errors++; $display("FAIL rnd_load_data: addr %h got %h expected %h", a, rd, exp_rd);
        end
        checks++;
        if (st != e || re_log.size() != ((e == 0) ? 0 : WORDS)) begin
          errors++; $display("FAIL rnd_load_timing: addr %h got stall=%0d beats=%0d expected stall=%0d",
                             a, st, re_log.size(), e);
        end
      end
    end
    checks++;
    if (overlap) begin
      errors++; $display("FAIL rnd_overlap: got mem_re&mem_we expected exclusive");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.cpu_addr  = '0;
    bus.cpu_re    = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_wdata = '0;
    test_reset();
    test_refill();
    test_hit();
    test_store_hit();
    test_store_miss();
    test_conflict();
    test_reset_refill();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
